// File: rtl/mc_core_ctrl_if.sv
// Control/status bundle between the multi-cycle main control FSM and the datapath.
// master = controller side, slave = datapath/IR side.
interface mc_core_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic             run;
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic             funct7b30;
    logic             alu_zero;
    logic             mem_ready;

    logic             mem_req;
    logic             mem_we;
    logic             addr_sel;
    logic             ir_we;
    logic             pc_we;
    logic             pc_sel;
    logic [1:0]       alu_op;
    logic [3:0]       alu_fn;
    logic             alu_src_b;
    logic             reg_we;
    logic             mem_to_reg;
    logic             busy;
    logic [1:0]       err;
    logic [CNT_W-1:0] retired;

    modport master (
        input  run, opcode, funct3, funct7b30, alu_zero, mem_ready,
        output mem_req, mem_we, addr_sel, ir_we, pc_we, pc_sel, alu_op, alu_fn,
               alu_src_b, reg_we, mem_to_reg, busy, err, retired
    );

    modport slave (
        output run, opcode, funct3, funct7b30, alu_zero, mem_ready,
        input  mem_req, mem_we, addr_sel, ir_we, pc_we, pc_sel, alu_op, alu_fn,
               alu_src_b, reg_we, mem_to_reg, busy, err, retired
    );
endinterface

// File: rtl/mc_core_ctrl.sv
// Multi-cycle main control FSM: fetch/decode/exec/mem/wb/branch sequencing for
// R-type ALU ops, LW, SW and BEQ, with memory timeout and retired counter.
module mc_core_ctrl #(
    parameter int unsigned ALU_SETTLE  = 1,
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    mc_core_ctrl_if.master bus
);
    localparam int unsigned EXEC_W = (ALU_SETTLE > 0) ? $clog2(ALU_SETTLE + 1) : 1;
    localparam int unsigned TO_W   = $clog2(MEM_TIMEOUT + 1);

    localparam logic [EXEC_W-1:0] EXEC_LAST = EXEC_W'(ALU_SETTLE);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(MEM_TIMEOUT - 1);

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_BR, S_HALT
    } state_t;

    typedef enum logic [1:0] {
        C_R, C_LW, C_SW, C_BEQ
    } cls_t;

    state_t            r_state;
    cls_t              r_cls;
    logic [1:0]        r_alu_op;
    logic [3:0]        r_alu_fn;
    logic [1:0]        r_err;
    logic [CNT_W-1:0]  r_retired;
    logic [EXEC_W-1:0] r_exec_cnt;
    logic [TO_W-1:0]   r_to_cnt;

    logic   w_mem_req;
    logic   w_wait;
    logic   w_timeout;
    logic   w_sw_done;
    logic   w_pc_we;
    state_t w_boundary;

    // Strobes are a pure decode of the current state so reset drops them at once.
    assign w_mem_req  = (r_state == S_FETCH) || (r_state == S_MEM);
    assign w_wait     = w_mem_req && !bus.mem_ready;
    assign w_timeout  = w_wait && (r_to_cnt == TO_LAST);
    assign w_sw_done  = (r_state == S_MEM) && (r_cls == C_SW) && bus.mem_ready;
    assign w_pc_we    = (r_state == S_WB) || (r_state == S_BR) || w_sw_done;
    assign w_boundary = bus.run ? S_FETCH : S_IDLE;

    assign bus.mem_req    = w_mem_req;
    assign bus.mem_we     = (r_state == S_MEM) && (r_cls == C_SW);
    assign bus.addr_sel   = (r_state == S_MEM);
    assign bus.ir_we      = (r_state == S_FETCH) && bus.mem_ready;
    assign bus.pc_we      = w_pc_we;
    assign bus.pc_sel     = (r_state == S_BR) && bus.alu_zero;
    assign bus.alu_op     = r_alu_op;
    assign bus.alu_fn     = r_alu_fn;
    assign bus.alu_src_b  = (r_state == S_EXEC) && ((r_cls == C_LW) || (r_cls == C_SW));
    assign bus.reg_we     = (r_state == S_WB);
    assign bus.mem_to_reg = (r_state == S_WB) && (r_cls == C_LW);
    assign bus.busy       = (r_state != S_IDLE) && (r_state != S_HALT);
    assign bus.err        = r_err;
    assign bus.retired    = r_retired;

    // State, latched instruction fields, error, and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cls      <= C_R;
            r_alu_op   <= 2'b00;
            r_alu_fn   <= 4'b0000;
            r_err      <= ERR_NONE;
            r_retired  <= '0;
            r_exec_cnt <= '0;
            r_to_cnt   <= '0;
        end else begin
            if (w_pc_we) begin
                r_retired <= r_retired + CNT_W'(1);
            end
            // Wait counter only runs while a request is outstanding; any other cycle clears it.
            if (w_wait) begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end else begin
                r_to_cnt <= '0;
            end

            case (r_state)
                S_IDLE: begin
                    if (bus.run) begin
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (bus.mem_ready) begin
                        r_state <= S_DECODE;
                    end else if (w_timeout) begin
                        r_state <= S_HALT;
                        r_err   <= ERR_TIMEOUT;
                    end
                end
                S_DECODE: begin
                    r_alu_fn   <= {bus.funct7b30, bus.funct3};
                    r_exec_cnt <= '0;
                    case (bus.opcode)
                        OP_R: begin
                            r_alu_op <= 2'b10;
                            r_cls    <= C_R;
                            r_state  <= S_EXEC;
                        end
                        OP_LW: begin
                            r_alu_op <= 2'b00;
                            r_cls    <= C_LW;
                            r_state  <= S_EXEC;
                        end
                        OP_SW: begin
                            r_alu_op <= 2'b00;
                            r_cls    <= C_SW;
                            r_state  <= S_EXEC;
                        end
                        OP_BEQ: begin
                            r_alu_op <= 2'b01;
                            r_cls    <= C_BEQ;
                            r_state  <= S_EXEC;
                        end
                        default: begin
                            r_state <= S_HALT;
                            r_err   <= ERR_ILLEGAL;
                        end
                    endcase
                end
                S_EXEC: begin
                    if (r_exec_cnt == EXEC_LAST) begin
                        case (r_cls)
                            C_R:     r_state <= S_WB;
                            C_BEQ:   r_state <= S_BR;
                            default: r_state <= S_MEM;
                        endcase
                    end else begin
                        r_exec_cnt <= r_exec_cnt + EXEC_W'(1);
                    end
                end
                S_MEM: begin
                    if (bus.mem_ready) begin
                        r_state <= (r_cls == C_SW) ? w_boundary : S_WB;
                    end else if (w_timeout) begin
                        r_state <= S_HALT;
                        r_err   <= ERR_TIMEOUT;
                    end
                end
                S_WB:    r_state <= w_boundary;
                S_BR:    r_state <= w_boundary;
                S_HALT:  r_state <= S_HALT;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mc_core_ctrl.sv
// Directed bench for mc_core_ctrl: hand-timed instruction sequences checked at the falling edge.
module tb_mc_core_ctrl;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mc_core_ctrl_if #(.CNT_W(16)) bif ();

    mc_core_ctrl #(
        .ALU_SETTLE (1),
        .MEM_TIMEOUT(16),
        .CNT_W      (16)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bif)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n         = 1'b0;
        bif.run       = 1'b0;
        bif.opcode    = 7'd0;
        bif.funct3    = 3'd0;
        bif.funct7b30 = 1'b0;
        bif.alu_zero  = 1'b0;
        bif.mem_ready = 1'b0;
        cyc(2);
        chk("rst_mem_req", 32'(bif.mem_req), 32'd0);
        chk("rst_busy",    32'(bif.busy),    32'd0);
        chk("rst_err",     32'(bif.err),     32'd0);
        chk("rst_retired", 32'(bif.retired), 32'd0);
        chk("rst_alu_op",  32'(bif.alu_op),  32'd0);
        chk("rst_alu_fn",  32'(bif.alu_fn),  32'd0);
        chk("rst_ir_we",   32'(bif.ir_we),   32'd0);
        chk("rst_pc_we",   32'(bif.pc_we),   32'd0);

        // ADD, memory ready on the second fetch cycle
        rst_n = 1'b1; bif.run = 1'b1; bif.opcode = OP_R;
        cyc(1);
        chk("add_f1_req",   32'(bif.mem_req),  32'd1);
        chk("add_f1_ir_we", 32'(bif.ir_we),    32'd0);
        chk("add_f1_addr",  32'(bif.addr_sel), 32'd0);
        chk("add_f1_busy",  32'(bif.busy),     32'd1);
        cyc(1);
        bif.mem_ready = 1'b1; #1;
        chk("add_f2_ir_we", 32'(bif.ir_we), 32'd1);
        cyc(1);
        bif.mem_ready = 1'b0;
        chk("add_dec_req", 32'(bif.mem_req), 32'd0);
        chk("add_dec_ir",  32'(bif.ir_we),   32'd0);
        cyc(1);
        chk("add_ex_op",   32'(bif.alu_op),    32'd2);
        chk("add_ex_fn",   32'(bif.alu_fn),    32'd0);
        chk("add_ex_srcb", 32'(bif.alu_src_b), 32'd0);
        cyc(1);
        chk("add_ex2_reg", 32'(bif.reg_we), 32'd0);
        chk("add_ex2_pc",  32'(bif.pc_we),  32'd0);
        cyc(1);
        chk("add_wb_reg",  32'(bif.reg_we),     32'd1);
        chk("add_wb_pc",   32'(bif.pc_we),      32'd1);
        chk("add_wb_m2r",  32'(bif.mem_to_reg), 32'd0);
        chk("add_wb_psel", 32'(bif.pc_sel),     32'd0);
        chk("add_wb_ret",  32'(bif.retired),    32'd0);
        cyc(1);
        chk("add_ret", 32'(bif.retired), 32'd1);
        chk("add_nxt", 32'(bif.mem_req), 32'd1);

        // LW then SW with memory always ready
        bif.opcode = OP_LW; bif.funct3 = 3'b010; bif.mem_ready = 1'b1; #1;
        chk("lw_ir_we", 32'(bif.ir_we), 32'd1);
        cyc(2);
        chk("lw_ex_op",   32'(bif.alu_op),    32'd0);
        chk("lw_ex_srcb", 32'(bif.alu_src_b), 32'd1);
        chk("lw_ex_fn",   32'(bif.alu_fn),    32'd2);
        cyc(2);
        chk("lw_mem_req", 32'(bif.mem_req),  32'd1);
        chk("lw_mem_we",  32'(bif.mem_we),   32'd0);
        chk("lw_mem_adr", 32'(bif.addr_sel), 32'd1);
        chk("lw_mem_pc",  32'(bif.pc_we),    32'd0);
        cyc(1);
        chk("lw_wb_m2r", 32'(bif.mem_to_reg), 32'd1);
        chk("lw_wb_reg", 32'(bif.reg_we),     32'd1);
        chk("lw_wb_pc",  32'(bif.pc_we),      32'd1);
        cyc(1);
        chk("lw_ret", 32'(bif.retired), 32'd2);
        bif.opcode = OP_SW;
        cyc(2);
        chk("sw_ex_srcb", 32'(bif.alu_src_b), 32'd1);
        cyc(2);
        chk("sw_mem_we",   32'(bif.mem_we),   32'd1);
        chk("sw_mem_pc",   32'(bif.pc_we),    32'd1);
        chk("sw_mem_reg",  32'(bif.reg_we),   32'd0);
        chk("sw_mem_psel", 32'(bif.pc_sel),   32'd0);
        chk("sw_mem_adr",  32'(bif.addr_sel), 32'd1);
        cyc(1);
        chk("sw_ret",    32'(bif.retired), 32'd3);
        chk("sw_nxt_rw", 32'(bif.reg_we),  32'd0);

        // BEQ taken, then BEQ not taken
        bif.opcode = OP_BEQ; bif.funct3 = 3'b000; bif.alu_zero = 1'b1;
        cyc(2);
        chk("beq1_ex_op",   32'(bif.alu_op),    32'd1);
        chk("beq1_ex_srcb", 32'(bif.alu_src_b), 32'd0);
        cyc(2);
        chk("beq1_br_pc",   32'(bif.pc_we),  32'd1);
        chk("beq1_br_psel", 32'(bif.pc_sel), 32'd1);
        chk("beq1_br_reg",  32'(bif.reg_we), 32'd0);
        cyc(1);
        chk("beq1_ret", 32'(bif.retired), 32'd4);
        bif.alu_zero = 1'b0;
        cyc(4);
        chk("beq0_br_pc",   32'(bif.pc_we),  32'd1);
        chk("beq0_br_psel", 32'(bif.pc_sel), 32'd0);
        chk("beq0_br_reg",  32'(bif.reg_we), 32'd0);
        cyc(1);
        chk("beq0_ret", 32'(bif.retired), 32'd5);

        // SUB with run dropped mid-instruction: completes, then idles
        bif.opcode = OP_R; bif.funct3 = 3'b000; bif.funct7b30 = 1'b1;
        cyc(2);
        bif.run = 1'b0;
        chk("sub_ex_fn", 32'(bif.alu_fn), 32'd8);
        chk("sub_ex_op", 32'(bif.alu_op), 32'd2);
        cyc(2);
        chk("sub_wb_reg",  32'(bif.reg_we), 32'd1);
        chk("sub_wb_busy", 32'(bif.busy),   32'd1);
        cyc(1);
        chk("sub_idle_busy", 32'(bif.busy),    32'd0);
        chk("sub_idle_req",  32'(bif.mem_req), 32'd0);
        chk("sub_ret",       32'(bif.retired), 32'd6);
        cyc(1);
        chk("sub_idle2_busy", 32'(bif.busy), 32'd0);

        // Ready on the 16th waiting fetch cycle completes normally
        bif.funct7b30 = 1'b0; bif.mem_ready = 1'b0; bif.run = 1'b1;
        cyc(1);
        chk("to_f1_req", 32'(bif.mem_req), 32'd1);
        cyc(15);
        chk("to_f16_busy", 32'(bif.busy), 32'd1);
        chk("to_f16_err",  32'(bif.err),  32'd0);
        bif.mem_ready = 1'b1; #1;
        chk("to_f16_ir", 32'(bif.ir_we), 32'd1);
        cyc(1);
        bif.mem_ready = 1'b0;
        chk("to_dec_err",  32'(bif.err),     32'd0);
        chk("to_dec_busy", 32'(bif.busy),    32'd1);
        chk("to_dec_req",  32'(bif.mem_req), 32'd0);
        cyc(3);
        chk("to_wb_pc", 32'(bif.pc_we), 32'd1);
        cyc(1);
        chk("to_ret", 32'(bif.retired), 32'd7);

        // Ready never arrives: timeout after 16 waiting cycles
        cyc(15);
        chk("to2_f16_req", 32'(bif.mem_req), 32'd1);
        chk("to2_f16_err", 32'(bif.err),     32'd0);
        cyc(1);
        chk("to2_halt_err",  32'(bif.err),     32'd2);
        chk("to2_halt_busy", 32'(bif.busy),    32'd0);
        chk("to2_halt_req",  32'(bif.mem_req), 32'd0);
        chk("to2_halt_ir",   32'(bif.ir_we),   32'd0);
        chk("to2_halt_ret",  32'(bif.retired), 32'd7);
        rst_n = 1'b0; #1;
        chk("to2_rst_err", 32'(bif.err),     32'd0);
        chk("to2_rst_ret", 32'(bif.retired), 32'd0);
        cyc(1);
        rst_n = 1'b1;

        // Illegal opcode halts; run toggling has no effect
        bif.opcode = 7'b1111111; bif.mem_ready = 1'b1; bif.run = 1'b1;
        cyc(3);
        chk("ill_err",  32'(bif.err),  32'd1);
        chk("ill_busy", 32'(bif.busy), 32'd0);
        bif.run = 1'b0;
        cyc(2);
        bif.run = 1'b1;
        cyc(2);
        chk("ill_hold_err",  32'(bif.err),     32'd1);
        chk("ill_hold_busy", 32'(bif.busy),    32'd0);
        chk("ill_hold_req",  32'(bif.mem_req), 32'd0);
        rst_n = 1'b0; #1;
        chk("ill_rst_err", 32'(bif.err), 32'd0);
        cyc(1);
        rst_n = 1'b1;

        // Reset asserted while in MEM drops outputs immediately
        bif.opcode = OP_LW; bif.funct3 = 3'b010; bif.mem_ready = 1'b1;
        cyc(2);
        bif.mem_ready = 1'b0;
        cyc(3);
        chk("mrst_mem_req", 32'(bif.mem_req),  32'd1);
        chk("mrst_mem_adr", 32'(bif.addr_sel), 32'd1);
        chk("mrst_busy",    32'(bif.busy),     32'd1);
        #2 rst_n = 1'b0; #1;
        chk("mrst_req",  32'(bif.mem_req),  32'd0);
        chk("mrst_adr",  32'(bif.addr_sel), 32'd0);
        chk("mrst_busy0", 32'(bif.busy),    32'd0);
        chk("mrst_op",   32'(bif.alu_op),   32'd0);
        chk("mrst_fn",   32'(bif.alu_fn),   32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
